// File: rtl/cam_frame_capture.sv
// cam_frame_capture: OV7670-style camera capture into an 8-bit frame buffer.
// Generates xclk, synchronises the camera pins into clk, packs two bytes per
// pixel (RGB565->RGB332 or Y-only) and writes the pixels inside the IMG_W x IMG_H
// window to the frame buffer.
// Optional feature macro: CAM_CAPTURE_CONT_EN (continuous back-to-back capture).
module cam_frame_capture #(
  parameter int AW       = 15,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int FMT      = 0,
  parameter int XCLK_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic          xclk,
  input  logic          pclk,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          frame_err,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [7:0]    mem_wr_data
);
  localparam logic [AW-1:0] W_L    = AW'(IMG_W);
  localparam logic [AW-1:0] H_L    = AW'(IMG_H);
  localparam logic [AW:0]   NPIX_L = (AW+1)'(IMG_W * IMG_H);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  // Pixel packing: FMT0 keeps R[7:5], G[5:3], B[4:3] of the RGB565 pair; FMT1 keeps Y.
  function automatic logic [7:0] pack_px(input logic [7:0] b0, input logic [1:0] b1_hi);
    if (FMT == 1) return b0;
    return {b0[7:5], b0[2:0], b1_hi};
  endfunction

  logic [XCLK_DIV-1:0] xcnt_q, xcnt_d;
  logic pclk_s1_q, pclk_s2_q, pclk_s3_q;
  logic href_s1_q, href_s2_q, href_s3_q;
  logic vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic vld_p0_q, href_p0_q, hfall_p0_q, vrise_p0_q, vfall_p0_q;
  logic vld_p1_q, href_p1_q, hfall_p1_q, vrise_p1_q, vfall_p1_q;
  logic [7:0] byte_p0_q, byte_p1_q;

  state_t          state_q, state_d;
  logic            phase_q, phase_d;
  logic [7:0]      b0_q, b0_d;
  logic [AW-1:0]   col_q, col_d, row_q, row_d, base_q, base_d;
  logic [AW:0]     stored_q, stored_d;
  logic            drop_q, drop_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;

  assign xcnt_d      = xcnt_q + 1'b1;
  assign xclk        = xcnt_q[XCLK_DIV-1];
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_err   = err_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;

  // Free-running xclk divider and two-flop synchronisers with edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xcnt_q    <= '0;
      pclk_s1_q <= 1'b0; pclk_s2_q <= 1'b0; pclk_s3_q <= 1'b0;
      href_s1_q <= 1'b0; href_s2_q <= 1'b0; href_s3_q <= 1'b0;
      vs_s1_q   <= 1'b0; vs_s2_q   <= 1'b0; vs_s3_q   <= 1'b0;
    end else begin
      xcnt_q    <= xcnt_d;
      pclk_s1_q <= pclk;      pclk_s2_q <= pclk_s1_q; pclk_s3_q <= pclk_s2_q;
      href_s1_q <= href;      href_s2_q <= href_s1_q; href_s3_q <= href_s2_q;
      vs_s1_q   <= vsync;     vs_s2_q   <= vs_s1_q;   vs_s3_q   <= vs_s2_q;
    end
  end

  // Event pipeline (p0, p1): byte events and sync edges stay aligned with their data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0_q <= 1'b0; href_p0_q <= 1'b0; hfall_p0_q <= 1'b0; vrise_p0_q <= 1'b0; vfall_p0_q <= 1'b0;
      vld_p1_q <= 1'b0; href_p1_q <= 1'b0; hfall_p1_q <= 1'b0; vrise_p1_q <= 1'b0; vfall_p1_q <= 1'b0;
    end else begin
      vld_p0_q   <= pclk_s2_q & ~pclk_s3_q;
      href_p0_q  <= href_s2_q;
      hfall_p0_q <= ~href_s2_q & href_s3_q;
      vrise_p0_q <= vs_s2_q & ~vs_s3_q;
      vfall_p0_q <= ~vs_s2_q & vs_s3_q;
      vld_p1_q   <= vld_p0_q;
      href_p1_q  <= href_p0_q;
      hfall_p1_q <= hfall_p0_q;
      vrise_p1_q <= vrise_p0_q;
      vfall_p1_q <= vfall_p0_q;
    end
  end

  // Camera data path registers; no reset needed, qualified by the valid pipeline.
  always_ff @(posedge clk) begin
    data_s1_q <= px_data;
    data_s2_q <= data_s1_q;
    byte_p0_q <= data_s2_q;
    byte_p1_q <= byte_p0_q;
  end

  // Capture FSM: frame sync, pixel assembly, window check and write generation.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    b0_d      = b0_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    stored_d  = stored_q;
    drop_d    = drop_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_VS;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      WAIT_VS: begin
        if (vfall_p1_q) begin
          state_d  = CAPTURE;
          col_d    = '0;
          row_d    = '0;
          base_d   = '0;
          phase_d  = 1'b0;
          stored_d = '0;
          drop_d   = 1'b0;
        end
      end
      CAPTURE: begin
        if (vrise_p1_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = (stored_q != NPIX_L) || drop_q;
`ifndef CAM_CAPTURE_CONT_EN
          busy_d  = 1'b0;
`endif
        end else if (hfall_p1_q) begin
          // Line end: an unpaired trailing byte is discarded via the phase reset.
          phase_d = 1'b0;
          col_d   = '0;
          if (col_q != '0) begin
            if (row_q < H_L) row_d = row_q + 1'b1;
            if ((row_q + 1'b1) < H_L) base_d = base_q + W_L;
          end
        end else if (vld_p1_q && href_p1_q) begin
          if (!phase_q) begin
            b0_d    = byte_p1_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((col_q < W_L) && (row_q < H_L)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = base_q + col_q;
              wr_data_d = pack_px(b0_q, byte_p1_q[4:3]);
              stored_d  = stored_q + 1'b1;
            end else begin
              drop_d = 1'b1;
            end
            if (col_q < W_L) col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
`ifdef CAM_CAPTURE_CONT_EN
        state_d = WAIT_VS;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      b0_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      stored_q  <= '0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      b0_q      <= b0_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      stored_q  <= stored_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture: two instances (RGB565 and YUV Y-only)
// share the camera stimulus; a frame-level model predicts writes, done and
// frame_err, and a per-cycle compare process checks both instances.
`timescale 1ns/1ps
module tb_cam_frame_capture;
  localparam int AW = 8, W = 4, H = 4, NPIX = W * H;
`ifdef CAM_CAPTURE_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, pclk = 1'b0, vsync = 1'b1, href = 1'b0, start = 1'b0;
  logic [7:0] px_data = 8'h00;
  logic xclk0, busy0, done0, err0, we0, xclk1, busy1, done1, err1, we1;
  logic [AW-1:0] wa0, wa1;
  logic [7:0] wd0, wd1;

  int total = 0, bad = 0, cyc = 0, rise_cyc = 0, tcase = 0, t2_idx = 0;
  int wr0_cnt = 0, wr1_cnt = 0, d0_cnt = 0, d1_cnt = 0, exp_done = 0;
  bit m_busy = 0, m_armed = 0, m_cap = 0, m_drop = 0;
  int m_row = 0, m_col = 0, m_stored = 0, fno = 0;
  logic [15:0] q0[$], q1[$];
  bit qe0[$], qe1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cam_frame_capture #(.AW(AW), .IMG_W(W), .IMG_H(H), .FMT(0), .XCLK_DIV(2)) u_dut0 (
    .clk(clk), .rst(rst), .xclk(xclk0), .pclk(pclk), .vsync(vsync), .href(href),
    .px_data(px_data), .start(start), .busy(busy0), .done(done0), .frame_err(err0),
    .mem_wr_en(we0), .mem_wr_addr(wa0), .mem_wr_data(wd0));

  cam_frame_capture #(.AW(AW), .IMG_W(W), .IMG_H(H), .FMT(1), .XCLK_DIV(2)) u_dut1 (
    .clk(clk), .rst(rst), .xclk(xclk1), .pclk(pclk), .vsync(vsync), .href(href),
    .px_data(px_data), .start(start), .busy(busy1), .done(done1), .frame_err(err1),
    .mem_wr_en(we1), .mem_wr_addr(wa1), .mem_wr_data(wd1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every write and done pulse against the model queues.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (we0) begin
        wr0_cnt++;
        if (tcase == 2) begin
          if (t2_idx == 0) chk("t2_latency", cyc - rise_cyc, 5);
          chk("t2_data_lit", wd0, 8'hE3);
          chk("t2_addr_lit", wa0, t2_idx);
          t2_idx++;
        end
        if (q0.size() == 0) chk("wr0_extra", 1, 0);
        else chk("wr0", {wa0, wd0}, q0.pop_front());
      end
      if (we1) begin
        wr1_cnt++;
        if (q1.size() == 0) chk("wr1_extra", 1, 0);
        else chk("wr1", {wa1, wd1}, q1.pop_front());
      end
      if (done0) begin
        d0_cnt++;
        chk("busy0_at_done", busy0, CONT);
        if (qe0.size() == 0) chk("done0_extra", 1, 0);
        else chk("err0", err0, qe0.pop_front());
      end
      if (done1) begin
        d1_cnt++;
        if (qe1.size() == 0) chk("done1_extra", 1, 0);
        else chk("err1", err1, qe1.pop_front());
      end
    end
  end

  function automatic logic [7:0] gen(input int kind, input int ln, input int i);
    if (kind == 0) return (i % 2 == 0) ? 8'hF8 : 8'h1F;
    return 8'(fno * 53 + ln * 37 + i * 11 + 3);
  endfunction

  // Model of one completed pixel: window check and expected frame-buffer contents.
  task automatic model_px(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] p0, a;
    if (!m_cap) return;
    if (m_col < W && m_row < H) begin
      a  = 8'(m_row * W + m_col);
      p0 = ((b0 >> 5) << 5) | ((b0 & 8'h07) << 2) | ((b1 >> 3) & 8'h03);
      q0.push_back({a, p0});
      q1.push_back({a, b0});
      m_stored++;
    end else begin
      m_drop = 1'b1;
    end
    m_col++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    px_data = b; href = 1'b1; pclk = 1'b0;
    repeat (3) @(negedge clk);
    pclk = 1'b1; rise_cyc = cyc;
    repeat (4) @(negedge clk);
    pclk = 1'b0;
  endtask

  task automatic send_line(input int nb, input int kind, input int ln);
    logic [7:0] b, b0;
    b0 = 8'h00;
    for (int i = 0; i < nb; i++) begin
      b = gen(kind, ln, i);
      if (i % 2 == 0) b0 = b;
      else model_px(b0, b);
      send_byte(b);
    end
    if (m_cap && nb >= 2 && m_row < H) m_row++;
    m_col = 0;
    @(negedge clk);
    href = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    if (!m_busy) begin m_busy = 1'b1; m_armed = 1'b1; end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk("t1_busy_before", busy0, 1);
    chk("t1_queue_drained", q0.size(), 0);
    rst = 1'b0;
    #1;
    chk("t1_rst_out0", {xclk0, busy0, done0, err0, we0, wa0, wd0}, 0);
    chk("t1_rst_out1", {xclk1, busy1, done1, err1, we1, wa1, wd1}, 0);
    m_busy = 1'b0; m_armed = 1'b0; m_cap = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(input int nl, input int nb, input int kind,
                            input int odd_ln, input int start_ln, input int rst_ln);
    vsync = 1'b1;
    repeat (12) @(negedge clk);
    vsync = 1'b0;
    if (m_armed) begin
      m_cap = 1'b1; m_row = 0; m_col = 0; m_stored = 0; m_drop = 1'b0;
    end
    repeat (12) @(negedge clk);
    for (int l = 0; l < nl; l++) begin
      if (l == start_ln) pulse_start();
      if (l == rst_ln) do_reset();
      send_line((l == odd_ln) ? 5 : nb, kind, l);
    end
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    if (m_cap) begin
      qe0.push_back((m_stored != NPIX) || m_drop);
      qe1.push_back((m_stored != NPIX) || m_drop);
      exp_done++;
      m_cap = 1'b0; m_armed = CONT; m_busy = CONT;
    end
    repeat (12) @(negedge clk);
    fno++;
  endtask

  initial begin
    int w0, d0, xr;
    logic xp;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out0", {xclk0, busy0, done0, err0, we0, wa0, wd0}, 0);
    chk("rst_out1", {xclk1, busy1, done1, err1, we1, wa1, wd1}, 0);
    rst = 1'b1;
    xp = xclk0; xr = 0;
    repeat (40) begin
      @(negedge clk);
      if (xclk0 && !xp) xr++;
      xp = xclk0;
    end
    chk("xclk_rises", xr, 10);

    // T2: clean RGB565 frame, every pixel F8/1F -> E3
    tcase = 2; w0 = wr0_cnt; d0 = d0_cnt;
    pulse_start();
    send_frame(4, 8, 0, -1, -1, -1);
    chk("t2_writes", wr0_cnt - w0, 16);
    chk("t2_done", d0_cnt - d0, 1);
    chk("t2_err0", err0, 0);
    chk("t2_err1", err1, 0);
    chk("t2_busy", busy0, CONT);

    // T3: oversize frame, 6 px lines and 5 lines into a 4x4 window
    tcase = 3; w0 = wr1_cnt;
    pulse_start();
    send_frame(5, 12, 1, -1, -1, -1);
    chk("t3_writes", wr1_cnt - w0, 16);
    chk("t3_err1", err1, 1);

    // T4: start mid-frame waits for next vsync fall; start while busy ignored
    tcase = 4; w0 = wr0_cnt;
    send_frame(4, 8, 1, -1, 1, -1);
    chk("t4_first_writes", wr0_cnt - w0, CONT ? 16 : 0);
    w0 = wr0_cnt;
    send_frame(4, 8, 1, -1, 2, -1);
    chk("t4_second_writes", wr0_cnt - w0, 16);
    chk("t4_err0", err0, 0);

    // T5: odd trailing byte on line 0 is discarded
    tcase = 5; w0 = wr0_cnt;
    pulse_start();
    send_frame(4, 8, 1, 0, -1, -1);
    chk("t5_writes", wr0_cnt - w0, 14);
    chk("t5_err0", err0, 1);

    // T1: reset mid-capture, then a fresh full frame
    tcase = 1; w0 = wr0_cnt; d0 = d0_cnt;
    pulse_start();
    send_frame(4, 8, 1, -1, -1, 2);
    chk("t1_partial_writes", wr0_cnt - w0, 8);
    chk("t1_no_done", d0_cnt - d0, 0);
    w0 = wr0_cnt;
    pulse_start();
    send_frame(4, 8, 1, -1, -1, -1);
    chk("t1_fresh_writes", wr0_cnt - w0, 16);
    chk("t1_err0", err0, 0);

    // T6: three frames after one start
    tcase = 6; w0 = wr0_cnt; d0 = d0_cnt;
    pulse_start();
    for (int f = 0; f < 3; f++) send_frame(4, 8, 1, -1, -1, -1);
    chk("t6_done", d0_cnt - d0, CONT ? 3 : 1);
    chk("t6_writes", wr0_cnt - w0, CONT ? 48 : 16);
    chk("t6_busy", busy0, CONT);

    repeat (10) @(negedge clk);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    chk("end_done0", d0_cnt, exp_done);
    chk("end_done1", d1_cnt, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
